// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-port owner encoding and arbiter defaults.
package cpu_pkg;
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

  localparam int STARVE_MAX_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-port signals around the shared port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus memory side.
  modport master (
    output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; sat flags the override point.
module arb_starve_ctr #(
  parameter int MAX = 4,
  localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic sat
);
  logic [W-1:0] cnt_q;

  assign sat = (cnt_q == W'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          cnt_q <= '0;
    else if (clr)        cnt_q <= '0;
    else if (inc && !sat) cnt_q <= cnt_q + W'(1);
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sync-read memory port between fetch and load/store; data has priority
// except when fetch has been starved STARVE_MAX cycles in a row.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave bus
);
  logic              sat;
  logic              fetch_wins;
  logic              d_win;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  owner_e            owner_q, owner_d;
  logic              kill_q;

  assign fetch_wins = bus.if_req & (~bus.d_req | sat);
  assign d_win      = bus.d_req & ~fetch_wins;
  assign bus.if_gnt = fetch_wins;
  assign bus.d_gnt  = d_win;

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (bus.if_req & ~fetch_wins),
    .clr   (fetch_wins | ~bus.if_req),
    .sat   (sat)
  );

  // Idle port drives zeros so the address bus does not toggle on no-op cycles.
  always_comb begin
    addr_d      = '0;
    wdata_d     = '0;
    bus.mem_en  = 1'b0;
    bus.mem_we  = 1'b0;
    if (d_win) begin
      bus.mem_en = 1'b1;
      bus.mem_we = bus.d_we;
      addr_d     = bus.d_addr;
      wdata_d    = bus.d_wdata;
    end else if (fetch_wins) begin
      bus.mem_en = 1'b1;
      addr_d     = bus.if_addr;
    end
  end
  assign bus.mem_addr  = addr_d;
  assign bus.mem_wdata = wdata_d;

  always_comb begin
    owner_d = OWN_NONE;
    if (fetch_wins)             owner_d = OWN_IF;
    else if (d_win && !bus.d_we) owner_d = OWN_D;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      kill_q  <= 1'b0;
    end else begin
      owner_q <= owner_d;
      kill_q  <= fetch_wins & bus.flush;
    end
  end

  // A flush in either the issue or the response cycle kills the fetch; loads are immune.
  assign bus.if_rvalid = (owner_q == OWN_IF) & ~kill_q & ~bus.flush;
  assign bus.d_rvalid  = (owner_q == OWN_D);
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.d_rdata   = bus.mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a write-first sync-read memory model.
module tb_mem_port_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [15:0] mem [256];
  logic [15:0] rdata_q;

  mem_port_arbiter_if bus();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        rdata_q <= bus.mem_wdata;
      end else begin
        rdata_q <= mem[bus.mem_addr[7:0]];
      end
    end
  end
  assign bus.mem_rdata = rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic set_in(input logic ifr, input logic [15:0] ifa, input logic dr,
                        input logic dwe, input logic [15:0] da, input logic [15:0] dwd,
                        input logic fl);
    bus.if_req  = ifr;
    bus.if_addr = ifa;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.flush   = fl;
  endtask

  task automatic idle(input logic fl);
    set_in(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, fl);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
    rdata_q = '0;
    set_in(1'b1, 16'h0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);

    // Reset with both requests high
    tick(); tick();
    #1;
    check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("rst_d_rvalid",  32'(bus.d_rvalid),  32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_d_gnt",  32'(bus.d_gnt),  32'd1);
    check("rel_if_gnt", 32'(bus.if_gnt), 32'd0);
    tick();
    idle(1'b0); #1;
    check("rel_ld_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("rel_ld_rdata",  32'(bus.d_rdata),  32'hA000);
    tick();

    // Solo fetch stream
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 16'(k), 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); #1;
      check("fs_if_gnt", 32'(bus.if_gnt), 32'd1);
      if (k > 0) begin
        check("fs_rvalid", 32'(bus.if_rvalid), 32'd1);
        check("fs_rdata",  32'(bus.if_rdata),  32'hA000 + 32'(k - 1));
      end
      tick();
    end
    idle(1'b0); #1;
    check("fs_rvalid_last", 32'(bus.if_rvalid), 32'd1);
    check("fs_rdata_last",  32'(bus.if_rdata),  32'hA002);
    check("idle_mem_en",    32'(bus.mem_en),    32'd0);
    check("idle_mem_addr",  32'(bus.mem_addr),  32'd0);
    tick();

    // Starvation override: D,D,D,D,IF repeated
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 16'h0020, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0); #1;
      check("sv_if_gnt", 32'(bus.if_gnt), (i == 4 || i == 9) ? 32'd1 : 32'd0);
      check("sv_d_gnt",  32'(bus.d_gnt),  (i == 4 || i == 9) ? 32'd0 : 32'd1);
      if (i == 4) begin
        check("sv_if_addr", 32'(bus.mem_addr), 32'h0020);
        check("sv_if_we",   32'(bus.mem_we),   32'd0);
      end
      tick();
    end
    idle(1'b0); tick();

    // Store then load to same address
    set_in(1'b0, 16'h0, 1'b1, 1'b1, 16'h0040, 16'h1234, 1'b0); #1;
    check("st_d_gnt",   32'(bus.d_gnt),     32'd1);
    check("st_mem_we",  32'(bus.mem_we),    32'd1);
    check("st_addr",    32'(bus.mem_addr),  32'h0040);
    check("st_wdata",   32'(bus.mem_wdata), 32'h1234);
    tick();
    set_in(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b0); #1;
    check("st_no_rsp",  32'(bus.d_rvalid),  32'd0);
    check("ld_mem_we",  32'(bus.mem_we),    32'd0);
    tick();
    idle(1'b0); #1;
    check("ld_rvalid",  32'(bus.d_rvalid),  32'd1);
    check("ld_rdata",   32'(bus.d_rdata),   32'h1234);
    tick();

    // Flush in the issue cycle
    set_in(1'b1, 16'h0005, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1); #1;
    check("fl1_if_gnt", 32'(bus.if_gnt), 32'd1);
    tick();
    idle(1'b0); #1;
    check("fl1_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();

    // Flush in the response cycle
    set_in(1'b1, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0); tick();
    idle(1'b1); #1;
    check("fl2_rvalid", 32'(bus.if_rvalid), 32'd0);
    tick();

    // Load response survives a flush
    set_in(1'b0, 16'h0, 1'b1, 1'b0, 16'h0007, 16'h0, 1'b0); tick();
    idle(1'b1); #1;
    check("fl3_d_rvalid", 32'(bus.d_rvalid), 32'd1);
    check("fl3_d_rdata",  32'(bus.d_rdata),  32'hA007);
    tick();
    idle(1'b0); tick();

    // Mid-operation reset: counter at 1 and a load in flight
    set_in(1'b1, 16'h0030, 1'b1, 1'b0, 16'h0008, 16'h0, 1'b0); tick();
    #1;
    check("mr_d_gnt", 32'(bus.d_gnt), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_async_kill", 32'(bus.d_rvalid), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mr_d_rvalid", 32'(bus.d_rvalid), 32'd0);
    check("mr_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    check("mr_owner", 32'(dut.owner_q), 32'(OWN_NONE));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) #1;
      check("mr_sv_if_gnt", 32'(bus.if_gnt), (i == 4) ? 32'd1 : 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous-read memory port of the pipeline CPU between instruction fetch (IF) and the load/store (data, D) stage. It grants at most one access per cycle, prioritises data over fetch with a bounded-starvation override, and routes the 1-cycle-latency read data back to its owner. A fetch response is discarded if it was killed by a branch flush.

## Interface
- `ADDR_W`, default 16: word address width.
- `DATA_W`, default 16: data width.
- `STARVE_MAX`, default 4: consecutive denied fetch cycles after which fetch wins one arbitration.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `flush` in 1: branch redirect; kills any fetch issued this cycle or in flight.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch issued this cycle (combinational).
- `if_rvalid` out 1: registered; `if_rdata` valid.
- `if_rdata` out DATA_W: fetch data (pass-through of `mem_rdata`).
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data address.
- `d_wdata` in DATA_W: store data.
- `d_gnt` out 1: data issued this cycle (combinational).
- `d_rvalid` out 1: registered; `d_rdata` valid (loads only).
- `d_rdata` out DATA_W: load data (pass-through of `mem_rdata`).
- `mem_en` out 1: port access this cycle.
- `mem_we` out 1: port write.
- `mem_addr` out ADDR_W: port address.
- `mem_wdata` out DATA_W: port write data.
- `mem_rdata` in DATA_W: port read data, valid the cycle after a read issue.

## Operation
- Grant, combinational, each cycle:
  - `fetch_wins = if_req & (~d_req | starve_cnt == STARVE_MAX)`.
  - `if_gnt = fetch_wins`.
  - `d_gnt = d_req & ~fetch_wins`.
  - Never both granted.
- Memory drive:
  - When `d_gnt`: `mem_en=1`, `mem_we=d_we`, and `mem_addr`/`mem_wdata` from D.
  - When `if_gnt`: `mem_en=1`, `mem_we=0`, `mem_addr=if_addr`.
  - Otherwise `mem_en=0`, `mem_we=0`, and addr/wdata hold 0.
- Starvation counter `starve_cnt` (width clog2(STARVE_MAX+1)):
  - Increments, saturating at STARVE_MAX, when `if_req & ~if_gnt`.
  - Clears when `if_gnt` or `~if_req`.
- In-flight owner register `owner` ∈ {NONE, IF, D}:
  - Next owner is IF on `if_gnt`.
  - Next owner is D on `d_gnt & ~d_we`.
  - Otherwise next owner is NONE.
  - Stores never produce a response.
- Kill bit `kill`:
  - Set next cycle when `if_gnt & flush`.
  - Cleared otherwise.
- Responses, cycle after issue:
  - `if_rvalid = (owner==IF) & ~kill & ~flush`.
  - `d_rvalid = (owner==D)`.
  - `flush` never suppresses data responses.
- Requesters hold `req` and address until granted; dropping an ungranted request is legal and clears nothing except per the counter rule.
- Back-to-back grants to either side are allowed every cycle (full throughput).

## Timing
- Issue latency: 0 cycles (grant in the request cycle).
- Read latency: 1 cycle (`*_rvalid` the cycle after grant).
- Reset values: `owner=NONE`, `kill=0`, `starve_cnt=0`.
  - Hence `if_rvalid=0` and `d_rvalid=0`.
  - Grant outputs follow the inputs.
- Reset mid-operation: any in-flight response is dropped, and no `rvalid` appears after `rst_n` rises.
- Simultaneous `if_req` & `d_req` with `starve_cnt<STARVE_MAX`: D wins and the counter increments.
- Simultaneous requests with `starve_cnt==STARVE_MAX`: IF wins, the counter clears, and D retries next cycle.
- Flush in the issue cycle and flush in the response cycle: both suppress that fetch's `if_rvalid`.
- Store followed by a load to the same address next cycle: the load returns the new data (memory is write-first; the arbiter adds no forwarding).

## Structure
- Shared package `cpu_pkg`:
  - Owner encoding `OWN_NONE=2'b00`, `OWN_IF=2'b01`, `OWN_D=2'b10`.
  - Default `STARVE_MAX`.
- One sub-module: `arb_starve_ctr`, the saturating counter with `inc`/`clr`, a `sat` output, and async active-low reset.
- Everything else is flat in `mem_port_arbiter`.

## Test plan
- **Reset.** Assert `rst_n=0` with both reqs high, release it → `if_rvalid=d_rvalid=0` while in reset. First cycle after release: `d_gnt=1`, `if_gnt=0`.
- **Solo fetch stream.** `if_req=1`, `if_addr` = 0x0000, 0x0001, 0x0002 on consecutive cycles, memory preloaded with 0xA000+addr → `if_rvalid` on 3 consecutive cycles with data 0xA000, 0xA001, 0xA002.
- **Starvation.** Both reqs held high for 10 cycles with STARVE_MAX=4 → grant pattern D,D,D,D,IF,D,D,D,D,IF.
- **Store/load.** D store to 0x0040 of 0x1234, then D load of 0x0040 → no `d_rvalid` for the store; `d_rvalid=1` with `d_rdata=0x1234` one cycle after the load grant.
- **Flush.**
  - Fetch granted with `flush=1` in the same cycle → `if_rvalid=0` next cycle.
  - Fetch granted, then `flush=1` in the response cycle → `if_rvalid=0`.
  - A load in flight during flush still returns `d_rvalid=1`.
- **Mid-operation reset.** Grant a load, then drop `rst_n` before the next edge → `d_rvalid` stays 0, `owner` returns to NONE, and `starve_cnt=0`.
